// File: rtl/pwtx_pkg.sv
// pwtx_pkg: shared encodings and defaults for the pulse-width LED link
package pwtx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } pwtx_state_e;

    localparam int BITS_PER_FRAME = 8;
    localparam int CNT_W          = $clog2(BITS_PER_FRAME);
    localparam int TIMER_W        = 4;
    localparam int SHORT_LOW_DEF  = 3;
    localparam int LONG_LOW_DEF   = 12;
    localparam int GAP_DEF        = 4;

    // Timer load value for the low pulse of one bit: a '1' is short, a '0' is long
    function automatic logic [TIMER_W-1:0] low_load(input logic b, input int s, input int l);
        return b ? TIMER_W'(s - 1) : TIMER_W'(l - 1);
    endfunction

endpackage

// File: rtl/pw_bit_timer.sv
// pw_bit_timer: loadable down-counter that flags when it reads zero
module pw_bit_timer
    import pwtx_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               done
);

    logic [TIMER_W-1:0] cnt_q, cnt_d;

    // Load wins; otherwise count down and park at zero
    always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);

    // Counter register
    always_ff @(posedge clock or posedge reset)
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;

    assign done = cnt_q == '0;

endmodule

// File: rtl/pulse_width_tx.sv
// pulse_width_tx: serialises one byte per handshake as pulse-width bits on txd (optional PWTX_FRAME_COUNT_EN adds frames counter)
module pulse_width_tx
    import pwtx_pkg::*;
#(
    parameter int SHORT_LOW = SHORT_LOW_DEF,
    parameter int LONG_LOW  = LONG_LOW_DEF,
    parameter int GAP       = GAP_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       txd,
    output logic       busy
`ifdef PWTX_FRAME_COUNT_EN
    ,
    output logic [7:0] frames
`endif
);

    pwtx_state_e        state_q, state_d;
    logic [7:0]         shreg_q, shreg_d;
    logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic               txd_q, txd_d;
    logic               ready_q, ready_d;
    logic               t_load;
    logic [TIMER_W-1:0] t_val;
    logic               t_done;

    pw_bit_timer u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (t_load),
        .load_val (t_val),
        .done     (t_done)
    );

    // Next-state logic: every state change reloads the timer with the new state's duration
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        txd_d    = txd_q;
        ready_d  = ready_q;
        t_load   = 1'b0;
        t_val    = '0;
        case (state_q)
            IDLE: if (valid && ready_q) begin
                state_d = LOW;
                shreg_d = data;
                txd_d   = 1'b0;
                ready_d = 1'b0;
                t_load  = 1'b1;
                t_val   = low_load(data[0], SHORT_LOW, LONG_LOW);
            end
            LOW: if (t_done) begin
                state_d  = HIGH;
                shreg_d  = {1'b0, shreg_q[7:1]};
                bitcnt_d = bitcnt_q + 1'b1;
                txd_d    = 1'b1;
                t_load   = 1'b1;
                t_val    = TIMER_W'(GAP - 1);
            end
            HIGH: if (t_done) begin
                if (bitcnt_q == '0) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end else begin
                    state_d = LOW;
                    txd_d   = 1'b0;
                    t_load  = 1'b1;
                    t_val   = low_load(shreg_q[0], SHORT_LOW, LONG_LOW);
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

    // FSM and datapath registers; reset forces the line back to marking at once
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            txd_q    <= 1'b1;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            txd_q    <= txd_d;
            ready_q  <= ready_d;
        end

    assign ready = ready_q;
    assign busy  = ~ready_q;
    assign txd   = txd_q;

`ifdef PWTX_FRAME_COUNT_EN
    logic [7:0] frames_q, frames_d;

    // A frame counts only when its final gap completes
    always_comb frames_d = (state_q == HIGH && t_done && bitcnt_q == '0) ? frames_q + 8'd1 : frames_q;

    // Frame counter register
    always_ff @(posedge clock or posedge reset)
        if (reset) frames_q <= '0;
        else       frames_q <= frames_d;

    assign frames = frames_q;
`endif

endmodule
